// File: rtl/shift_register_universal_pkg.sv
// rtl/shift_register_universal_pkg.sv - mode and burst-state encodings shared by the shift register files
package shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_register_universal_if.sv
// rtl/shift_register_universal_if.sv - control, data and status bundle of the universal shift register
interface shift_register_universal_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] D;
  logic [1:0]       mode;
  logic             sin_l;
  logic             sin_r;
  logic             burst_start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] Q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output en, load, D, mode, sin_l, sin_r, burst_start, burst_len,
    input  Q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  en, load, D, mode, sin_l, sin_r, burst_start, burst_len,
    output Q, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/shift_register_universal_burst_ctrl.sv
// rtl/shift_register_universal_burst_ctrl.sv - burst counter/state machine issuing shift strobes and modes
module shift_burst_ctrl
  import shift_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [1:0]       mode,
  output logic             step,
  output mode_e            step_mode,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= SHL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (en) begin
      if (load) begin
        // A load aborts any burst silently.
        state_d = IDLE;
        cnt_d   = '0;
      end else if (state_q == RUN) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else if (burst_start) begin
        if (burst_len != '0) begin
          state_d = RUN;
          cnt_d   = burst_len;
          mode_d  = mode_e'(mode);
        end else begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = done_q;
    // An accepted or zero-length burst_start consumes the edge without shifting.
    step      = en && !load && ((state_q == RUN) || !burst_start);
    step_mode = (state_q == RUN) ? mode_q : mode_e'(mode);
  end

endmodule

// File: rtl/shift_register_universal.sv
// rtl/shift_register_universal.sv - WIDTH-bit universal shift register with parallel load and burst engine
module shift_register_universal
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  shift_register_universal_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             step;
  mode_e            step_mode;
  logic             busy;
  logic             done;

  shift_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (bus.en),
    .load        (bus.load),
    .burst_start (bus.burst_start),
    .burst_len   (bus.burst_len),
    .mode        (bus.mode),
    .step        (step),
    .step_mode   (step_mode),
    .busy        (busy),
    .done        (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  always_comb begin
    q_d = q_q;
    if (bus.en && bus.load) begin
      q_d = bus.D;
    end else if (step) begin
      case (step_mode)
        SHL: q_d = {q_q[WIDTH-2:0], bus.sin_l};
        SHR: q_d = {bus.sin_r, q_q[WIDTH-1:1]};
        ROL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ROR: q_d = {q_q[0], q_q[WIDTH-1:1]};
        default: q_d = q_q;
      endcase
    end
  end

  assign bus.Q      = q_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule
